// File: rtl/lsq_ring.sv
// Circular load-store queue: program-order allocation, oldest-first issue with
// store-to-load forwarding, in-order store commit, ROB-driven retire and flush.

module lsq_entry #(
  parameter int TAG_W  = 6,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              alloc,
  input  logic              alloc_store,
  input  logic [TAG_W-1:0]  alloc_tag,
  input  logic [DATA_W-1:0] alloc_data,
  input  logic              agu_valid,
  input  logic [TAG_W-1:0]  agu_tag,
  input  logic [ADDR_W-1:0] agu_addr,
  input  logic              pop,
  input  logic              set_issued,
  input  logic              set_done,
  output logic              vld,
  output logic              is_store,
  output logic [TAG_W-1:0]  tag,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_ok,
  output logic [DATA_W-1:0] data,
  output logic              issued,
  output logic              done
);

  // An address arriving for an entry that is retiring this cycle is dropped.
  logic agu_hit;
  assign agu_hit = agu_valid && vld && (tag == agu_tag) && !pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld      <= 1'b0;
      is_store <= 1'b0;
      tag      <= '0;
      addr     <= '0;
      addr_ok  <= 1'b0;
      data     <= '0;
      issued   <= 1'b0;
      done     <= 1'b0;
    end else if (flush || pop) begin
      vld <= 1'b0;
    end else if (alloc) begin
      vld      <= 1'b1;
      is_store <= alloc_store;
      tag      <= alloc_tag;
      data     <= alloc_data;
      addr     <= '0;
      addr_ok  <= 1'b0;
      issued   <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (agu_hit) begin
        addr    <= agu_addr;
        addr_ok <= 1'b1;
      end
      if (set_issued) issued <= 1'b1;
      if (set_done)   done   <= 1'b1;
    end
  end

endmodule

module lsq_ring #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 6,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   dis_valid,
  output logic                   dis_ready,
  input  logic                   dis_is_store,
  input  logic [TAG_W-1:0]       dis_tag,
  input  logic [DATA_W-1:0]      dis_data,
  input  logic                   agu_valid,
  input  logic [TAG_W-1:0]       agu_tag,
  input  logic [ADDR_W-1:0]      agu_addr,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic                   iss_is_store,
  output logic [TAG_W-1:0]       iss_tag,
  output logic [ADDR_W-1:0]      iss_addr,
  output logic [DATA_W-1:0]      iss_data,
  output logic                   fwd_valid,
  output logic [TAG_W-1:0]       fwd_tag,
  output logic [DATA_W-1:0]      fwd_data,
  input  logic                   ret_valid,
  input  logic [TAG_W-1:0]       ret_tag,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef struct packed {
    logic              is_store;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } iss_op_t;

  logic [PTR_W-1:0] head, tail;
  logic [IDX_W-1:0] head_idx, tail_idx;

  logic [DEPTH-1:0]             e_v, e_st, e_aok, e_iss, e_done;
  logic [DEPTH-1:0][TAG_W-1:0]  e_tag;
  logic [DEPTH-1:0][ADDR_W-1:0] e_addr;
  logic [DEPTH-1:0][DATA_W-1:0] e_data;
  logic [DEPTH-1:0]             alloc_v, pop_v, set_iss_v, set_done_v;

  iss_op_t          iss_q;
  logic [IDX_W-1:0] iss_slot;

  assign head_idx  = head[IDX_W-1:0];
  assign tail_idx  = tail[IDX_W-1:0];
  assign count     = tail - head;
  assign empty     = (head == tail);
  assign full      = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
  assign dis_ready = !full;

  logic do_dis, do_ret, sel_en, iss_acc;
  assign do_dis  = dis_valid && !full && !flush;
  assign do_ret  = ret_valid && !flush && e_v[head_idx] && e_done[head_idx] &&
                   (e_tag[head_idx] == ret_tag);
  assign iss_acc = iss_valid && iss_ready;
  assign sel_en  = !(iss_valid && !iss_ready);

  // Oldest-first scan from head. Loads wait behind any older store whose
  // address is still unknown; stores only go when they sit at head.
  logic             sel_found, scan_blocked;
  logic [IDX_W-1:0] sel_slot, scan_s;
  logic [DEPTH-1:0] older;

  always_comb begin
    sel_found    = 1'b0;
    sel_slot     = '0;
    scan_blocked = 1'b0;
    scan_s       = '0;
    older        = '0;
    for (int p = 0; p < DEPTH; p++) begin
      scan_s        = head_idx + IDX_W'(p);
      older[scan_s] = !sel_found;
      if (!sel_found && e_v[scan_s] && e_aok[scan_s] && !e_iss[scan_s] &&
          (e_st[scan_s] ? (p == 0) : !scan_blocked)) begin
        sel_found = 1'b1;
        sel_slot  = scan_s;
      end
      if (e_v[scan_s] && e_st[scan_s] && !e_aok[scan_s]) scan_blocked = 1'b1;
    end
  end

  // Youngest older store with a matching address supplies the load's data.
  logic              fwd_hit, fwd_go;
  logic [DATA_W-1:0] fwd_sel;
  logic [IDX_W-1:0]  fscan_s;

  always_comb begin
    fwd_hit = 1'b0;
    fwd_sel = '0;
    fscan_s = '0;
    for (int q = 0; q < DEPTH; q++) begin
      fscan_s = head_idx + IDX_W'(q);
      if (older[fscan_s] && e_v[fscan_s] && e_st[fscan_s] &&
          (e_addr[fscan_s] == e_addr[sel_slot])) begin
        fwd_hit = 1'b1;
        fwd_sel = e_data[fscan_s];
      end
    end
  end

  assign fwd_go = sel_found && !e_st[sel_slot] && fwd_hit;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign alloc_v[i]    = do_dis && (tail_idx == IDX_W'(i));
    assign pop_v[i]      = do_ret && (head_idx == IDX_W'(i));
    assign set_iss_v[i]  = !flush && sel_en && sel_found && (sel_slot == IDX_W'(i));
    assign set_done_v[i] = !flush && ((iss_acc && (iss_slot == IDX_W'(i))) ||
                                      (sel_en && fwd_go && (sel_slot == IDX_W'(i))));

    lsq_entry #(.TAG_W(TAG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ent (
      .clk        (clk),
      .rstn       (rstn),
      .flush      (flush),
      .alloc      (alloc_v[i]),
      .alloc_store(dis_is_store),
      .alloc_tag  (dis_tag),
      .alloc_data (dis_data),
      .agu_valid  (agu_valid),
      .agu_tag    (agu_tag),
      .agu_addr   (agu_addr),
      .pop        (pop_v[i]),
      .set_issued (set_iss_v[i]),
      .set_done   (set_done_v[i]),
      .vld        (e_v[i]),
      .is_store   (e_st[i]),
      .tag        (e_tag[i]),
      .addr       (e_addr[i]),
      .addr_ok    (e_aok[i]),
      .data       (e_data[i]),
      .issued     (e_iss[i]),
      .done       (e_done[i])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head      <= '0;
      tail      <= '0;
      iss_valid <= 1'b0;
      iss_q     <= '0;
      iss_slot  <= '0;
      fwd_valid <= 1'b0;
      fwd_tag   <= '0;
      fwd_data  <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      iss_valid <= 1'b0;
      fwd_valid <= 1'b0;
    end else begin
      if (do_ret) head <= head + PTR_W'(1);
      if (do_dis) tail <= tail + PTR_W'(1);
      fwd_valid <= 1'b0;
      if (sel_en) begin
        if (fwd_go) begin
          fwd_valid <= 1'b1;
          fwd_tag   <= e_tag[sel_slot];
          fwd_data  <= fwd_sel;
          iss_valid <= 1'b0;
        end else if (sel_found) begin
          iss_valid      <= 1'b1;
          iss_slot       <= sel_slot;
          iss_q.is_store <= e_st[sel_slot];
          iss_q.tag      <= e_tag[sel_slot];
          iss_q.addr     <= e_addr[sel_slot];
          iss_q.data     <= e_st[sel_slot] ? e_data[sel_slot] : '0;
        end else begin
          iss_valid <= 1'b0;
        end
      end
    end
  end

  assign iss_is_store = iss_q.is_store;
  assign iss_tag      = iss_q.tag;
  assign iss_addr     = iss_q.addr;
  assign iss_data     = iss_q.data;

endmodule
